// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and completion bundle between the instruction source
// and the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic              instr_imm_en;
    logic [DATA_W-1:0] instr_imm;
    logic              done_valid;
    logic [DATA_W-1:0] done_result;
    logic              err;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
               instr_imm_en, instr_imm,
        input  instr_ready, done_valid, done_result, err
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
               instr_imm_en, instr_imm,
        output instr_ready, done_valid, done_result, err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequencer that issues register/immediate operands to a combinational 4-bit ALU,
// captures its result and flags, and writes the result back to a small register file.
module alu_issue_ctrl #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   instr_if,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ZF,
    input  logic              alu_SF,
    input  logic              alu_OF,
    output logic [2:0]        flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_CMP     = 3'b110;
    localparam logic [2:0] OP_INVALID = 3'b111;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] regfile [NREGS];
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] result_q;
    logic [2:0]        cap_flags;
    logic              accept;
    logic              wb_write;
    logic              flags_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (instr_if.instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // alu_op keeps the accepted opcode through WB, so it also qualifies the writeback.
    assign wb_write    = (state == WB) && (alu_op != OP_CMP) && (alu_op != OP_INVALID);
    assign flags_write = (state == WB) && (alu_op != OP_INVALID);

    assign instr_if.instr_ready = (state == IDLE);
    assign instr_if.done_valid  = (state == WB);
    assign instr_if.err         = (state == WB) && (alu_op == OP_INVALID);
    assign instr_if.done_result = result_q;
    assign dbg_data             = regfile[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_A     <= '0;
            alu_B     <= '0;
            alu_op    <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            cap_flags <= '0;
            flags     <= '0;
        end else begin
            if (accept) begin
                alu_A  <= regfile[instr_if.instr_rs1];
                alu_B  <= instr_if.instr_imm_en ? instr_if.instr_imm
                                                : regfile[instr_if.instr_rs2];
                alu_op <= instr_if.instr_op;
                rd_q   <= instr_if.instr_rd;
            end
            if (state == EXEC) begin
                result_q  <= alu_result;
                cap_flags <= {alu_ZF, alu_SF, alu_OF};
            end
            if (flags_write) begin
                flags <= cap_flags;
            end
        end
    end

    // The writeback assignment comes last so it wins over a host load to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regfile[ld_addr] <= ld_data;
            end
            if (wb_write) begin
                regfile[rd_q] <= result_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level model.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_ZF;
    logic       alu_SF;
    logic       alu_OF;
    logic [2:0] flags;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    alu_issue_ctrl_if #(.DATA_W(4), .ADDR_W(2)) bus ();

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_if   (bus),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_ZF     (alu_ZF),
        .alu_SF     (alu_SF),
        .alu_OF     (alu_OF),
        .flags      (flags)
    );

    // Reference ALU: returns {result, ZF, SF, OF}.
    function automatic logic [6:0] aluCalc(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [3:0] r;
        logic       o;
        r = 4'd0;
        o = 1'b0;
        case (op)
            3'd0: begin r = a + b; o = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1, 3'd6: begin r = a - b; o = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = 4'($signed(a) >>> b[1:0]);
            3'd5: r = a << b[1:0];
            default: r = 4'd0;
        endcase
        return {r, (r == 4'd0), r[3], o};
    endfunction

    always_comb begin
        {alu_result, alu_ZF, alu_SF, alu_OF} = aluCalc(alu_op, alu_A, alu_B);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding instruction with its age since accept.
    logic [3:0] m_rf [4];
    logic [2:0] m_flags;
    logic       p_valid;
    int         p_age;
    logic [2:0] p_op;
    logic [1:0] p_rd;
    logic [3:0] p_a, p_b;
    logic [3:0] e_a, e_b;
    logic [2:0] e_op;

    always @(negedge clk) begin : model
        logic [6:0] r;
        logic       acc;
        logic [3:0] na, nb;
        if (!rst_n) begin
            p_valid = 1'b0;
            p_age   = 0;
            p_op    = 3'd0;
            p_rd    = 2'd0;
            p_a     = 4'd0;
            p_b     = 4'd0;
            m_flags = 3'd0;
            e_a     = 4'd0;
            e_b     = 4'd0;
            e_op    = 3'd0;
            for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        end else begin
            r = aluCalc(p_op, p_a, p_b);
            checkOutput("instr_ready", 8'(bus.instr_ready), 8'(!p_valid));
            checkOutput("alu_A", 8'(alu_A), 8'(e_a));
            checkOutput("alu_B", 8'(alu_B), 8'(e_b));
            checkOutput("alu_op", 8'(alu_op), 8'(e_op));
            checkOutput("done_valid", 8'(bus.done_valid), 8'(p_valid && p_age == 2));
            checkOutput("err", 8'(bus.err), 8'(p_valid && p_age == 2 && p_op == 3'd7));
            if (p_valid && p_age == 2) begin
                checkOutput("done_result", 8'(bus.done_result), 8'(r[6:3]));
            end
            checkOutput("flags", 8'(flags), 8'(m_flags));
            checkOutput("dbg_data", 8'(dbg_data), 8'(m_rf[dbg_addr]));

            acc = !p_valid && bus.instr_valid;
            na  = m_rf[bus.instr_rs1];
            nb  = bus.instr_imm_en ? bus.instr_imm : m_rf[bus.instr_rs2];
            if (ld_en) m_rf[ld_addr] = ld_data;
            if (p_valid && p_age == 2) begin
                if (p_op < 3'd6) m_rf[p_rd] = r[6:3];
                if (p_op != 3'd7) m_flags = r[2:0];
                p_valid = 1'b0;
            end else if (p_valid) begin
                p_age = 2;
            end
            if (acc) begin
                p_valid = 1'b1;
                p_age   = 1;
                p_op    = bus.instr_op;
                p_rd    = bus.instr_rd;
                p_a     = na;
                p_b     = nb;
                e_a     = na;
                e_b     = nb;
                e_op    = bus.instr_op;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadReg(input logic [1:0] addr, input logic [3:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    // Offers one instruction and returns just after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd,
                                 input logic [1:0] rs1, input logic [1:0] rs2,
                                 input logic imm_en, input logic [3:0] imm,
                                 output int acc_cycle);
        logic rdy;
        logic accepted;
        accepted         = 1'b0;
        acc_cycle        = -1;
        bus.instr_valid  = 1'b1;
        bus.instr_op     = op;
        bus.instr_rd     = rd;
        bus.instr_rs1    = rs1;
        bus.instr_rs2    = rs2;
        bus.instr_imm_en = imm_en;
        bus.instr_imm    = imm;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = bus.instr_ready;
            tick();
            if (rdy) begin
                accepted  = 1'b1;
                acc_cycle = cycle;
                break;
            end
        end
        bus.instr_valid = 1'b0;
        checks++;
        if (!accepted) begin
            failures++;
            $display("[TB] FAIL accept_wait actual=not_accepted required=accepted");
        end
    endtask

    task automatic checkDbg(input string name, input logic [1:0] addr, input logic [3:0] exp);
        dbg_addr = addr;
        #1;
        checkOutput(name, 8'(dbg_data), 8'(exp));
    endtask

    initial begin : stim
        int  a0, a1;
        logic rdy;
        rst_n            = 1'b0;
        ld_en            = 1'b0;
        ld_addr          = 2'd0;
        ld_data          = 4'd0;
        dbg_addr         = 2'd0;
        bus.instr_valid  = 1'b0;
        bus.instr_op     = 3'd0;
        bus.instr_rd     = 2'd0;
        bus.instr_rs1    = 2'd0;
        bus.instr_rs2    = 2'd0;
        bus.instr_imm_en = 1'b0;
        bus.instr_imm    = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 8'(bus.instr_ready), 8'd1);
        checkOutput("reset_flags", 8'(flags), 8'd0);
        checkOutput("reset_done", 8'(bus.done_valid), 8'd0);
        tick();

        // 1: register ADD
        loadReg(2'd0, 4'd3);
        loadReg(2'd1, 4'd4);
        applyStimulus(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, a0);
        @(negedge clk);
        checkOutput("t1_alu_A", 8'(alu_A), 8'd3);
        checkOutput("t1_alu_B", 8'(alu_B), 8'd4);
        checkOutput("t1_alu_op", 8'(alu_op), 8'd0);
        tick();
        @(negedge clk);
        checkOutput("t1_done_valid", 8'(bus.done_valid), 8'd1);
        checkOutput("t1_done_result", 8'(bus.done_result), 8'd7);
        tick();
        checkOutput("t1_flags", 8'(flags), 8'd0);
        checkDbg("t1_r2", 2'd2, 4'd7);

        // 2: immediate ADD with signed overflow
        loadReg(2'd0, 4'd7);
        applyStimulus(3'd0, 2'd3, 2'd0, 2'd1, 1'b1, 4'd7, a0);
        tick();
        @(negedge clk);
        checkOutput("t2_done_result", 8'(bus.done_result), 8'he);
        tick();
        checkOutput("t2_flags", 8'(flags), 8'b011);
        checkDbg("t2_r3", 2'd3, 4'd14);

        // 3: SUB with rd equal to both sources
        loadReg(2'd1, 4'd3);
        applyStimulus(3'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0, a0);
        tick();
        @(negedge clk);
        checkOutput("t3_done_result", 8'(bus.done_result), 8'd0);
        tick();
        checkOutput("t3_flags", 8'(flags), 8'b100);
        checkDbg("t3_r1", 2'd1, 4'd0);

        // 4: CMP updates flags only, then an invalid op
        loadReg(2'd0, 4'd5);
        loadReg(2'd1, 4'd3);
        loadReg(2'd2, 4'd9);
        applyStimulus(3'd6, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, a0);
        tick();
        @(negedge clk);
        checkOutput("t4_cmp_done", 8'(bus.done_valid), 8'd1);
        checkOutput("t4_cmp_result", 8'(bus.done_result), 8'd2);
        tick();
        checkOutput("t4_cmp_flags", 8'(flags), 8'b000);
        checkDbg("t4_r2_kept", 2'd2, 4'd9);
        applyStimulus(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 4'd0, a0);
        tick();
        @(negedge clk);
        checkOutput("t4_err", 8'(bus.err), 8'd1);
        checkOutput("t4_err_done", 8'(bus.done_valid), 8'd1);
        tick();
        checkOutput("t4_err_flags", 8'(flags), 8'b000);
        checkDbg("t4_r1_kept", 2'd1, 4'd3);

        // 5: back-to-back with a RAW dependency on the first destination
        loadReg(2'd0, 4'd1);
        loadReg(2'd1, 4'd2);
        applyStimulus(3'd0, 2'd3, 2'd0, 2'd1, 1'b0, 4'd0, a0);
        applyStimulus(3'd0, 2'd2, 2'd3, 2'd0, 1'b1, 4'd4, a1);
        checkOutput("t5_accept_gap", 8'(a1 - a0), 8'd3);
        @(negedge clk);
        checkOutput("t5_raw_operand", 8'(alu_A), 8'd3);
        tick();
        @(negedge clk);
        checkOutput("t5_result", 8'(bus.done_result), 8'd7);
        tick();

        // 6: reset during EXEC aborts, then a host load collides with writeback
        applyStimulus(3'd0, 2'd1, 2'd0, 2'd1, 1'b0, 4'd0, a0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_ready", 8'(bus.instr_ready), 8'd1);
        checkOutput("t6_done", 8'(bus.done_valid), 8'd0);
        checkOutput("t6_flags", 8'(flags), 8'd0);
        for (int i = 0; i < 4; i++) checkDbg("t6_reg_clear", 2'(i), 4'd0);
        tick();
        loadReg(2'd0, 4'd2);
        loadReg(2'd1, 4'd3);
        applyStimulus(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, a0);
        tick();
        ld_en   = 1'b1;
        ld_addr = 2'd2;
        ld_data = 4'hf;
        tick();
        ld_en = 1'b0;
        checkDbg("t6_wb_wins", 2'd2, 4'd5);

        // Randomized traffic, checked by the model on every cycle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rdy = bus.instr_ready;
            tick();
            if (!bus.instr_valid || rdy) begin
                bus.instr_valid  = ($urandom_range(0, 2) != 0);
                bus.instr_op     = 3'($urandom_range(0, 7));
                bus.instr_rd     = 2'($urandom_range(0, 3));
                bus.instr_rs1    = 2'($urandom_range(0, 3));
                bus.instr_rs2    = 2'($urandom_range(0, 3));
                bus.instr_imm_en = 1'($urandom_range(0, 1));
                bus.instr_imm    = 4'($urandom_range(0, 15));
            end
            ld_en    = ($urandom_range(0, 3) == 0);
            ld_addr  = 2'($urandom_range(0, 3));
            ld_data  = 4'($urandom_range(0, 15));
            dbg_addr = 2'($urandom_range(0, 3));
        end
        bus.instr_valid = 1'b0;
        ld_en           = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
